md_command_sequencer: RTL

//  Initiator for the sequential multiplier/divider engine's operand-load/start/ready interface.

---
 rtl/md_pkg.sv | 25 ++
 rtl/md_watchdog.sv | 31 +++
 rtl/md_command_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types for the multiply/divide command sequencer.
package md_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_A,
        REL_A,
        LOAD_B,
        REL_B,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } md_state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // States that wait on the engine and are therefore bounded by the watchdog.
    function automatic logic is_wait_state(input md_state_e s);
        return (s == LOAD_A) || (s == REL_A) || (s == LOAD_B) || (s == REL_B) ||
               (s == WAIT_BUSY) || (s == WAIT_DONE);
    endfunction

endpackage

// File: rtl/md_watchdog.sv
// Per-state wait counter: cleared on every state change, counts while enabled,
// flags the LIMIT-th consecutive enabled cycle.
module md_watchdog #(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Cycle counter for the current wait state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != CW'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Independent of clear so the FSM can use it without a combinational loop.
    assign expire = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/md_command_sequencer.sv
// Request/response front end for the sequential multiply/divide engine.
// Optional feature: define MD_TIMEOUT_EN to bound every engine wait by TIMEOUT_CYCLES.
module md_command_sequencer
    import md_pkg::*;
#(
    parameter int unsigned WORD_LENGTH    = 9,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_op,
    input  logic [WORD_LENGTH-1:0]   req_a,
    input  logic [WORD_LENGTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*WORD_LENGTH-1:0] rsp_result,
    output logic                     rsp_err,
    output logic [WORD_LENGTH-1:0]   md_data,
    output logic                     md_load,
    output logic                     md_op,
    output logic                     md_start,
    input  logic                     md_stored,
    input  logic                     md_ready,
    input  logic [2*WORD_LENGTH-1:0] md_result
);

    localparam int unsigned W = WORD_LENGTH;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("md_command_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    md_state_e        state, next;
    logic             op_q, n_op;
    logic [W-1:0]     a_q, n_a, b_q, n_b;
    logic             wb_second, n_wb_second;
    logic             state_change;
    logic             wd_expire;

    logic             n_req_ready, n_rsp_valid, n_rsp_err, n_md_load, n_md_op, n_md_start;
    logic [2*W-1:0]   n_rsp_result;
    logic [W-1:0]     n_md_data;

`ifdef MD_TIMEOUT_EN
    md_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_change),
        .enable (is_wait_state(state)),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    // State, latched request and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            wb_second  <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            md_data    <= '0;
            md_load    <= 1'b0;
            md_op      <= 1'b0;
            md_start   <= 1'b0;
        end else begin
            state      <= next;
            op_q       <= n_op;
            a_q        <= n_a;
            b_q        <= n_b;
            wb_second  <= n_wb_second;
            req_ready  <= n_req_ready;
            rsp_valid  <= n_rsp_valid;
            rsp_result <= n_rsp_result;
            rsp_err    <= n_rsp_err;
            md_data    <= n_md_data;
            md_load    <= n_md_load;
            md_op      <= n_md_op;
            md_start   <= n_md_start;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        next         = state;
        n_op         = op_q;
        n_a          = a_q;
        n_b          = b_q;
        n_wb_second  = 1'b0;
        n_rsp_result = rsp_result;
        n_rsp_err    = rsp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    n_op = req_op;
                    n_a  = req_a;
                    n_b  = req_b;
                    if (req_op == OP_DIV && req_b == '0) begin
                        next         = RESP;
                        n_rsp_err    = 1'b1;
                        n_rsp_result = '0;
                    end else begin
                        next      = LOAD_A;
                        n_rsp_err = 1'b0;
                    end
                end
            end
            LOAD_A:    if (md_stored)  next = REL_A;
            REL_A:     if (!md_stored) next = LOAD_B;
            LOAD_B:    if (md_stored)  next = REL_B;
            REL_B:     if (!md_stored) next = START;
            START:     next = WAIT_BUSY;
            WAIT_BUSY: begin
                // An engine that never drops ready is assumed to have finished already.
                if (!md_ready || wb_second) next = WAIT_DONE;
                else                        n_wb_second = 1'b1;
            end
            WAIT_DONE: begin
                if (md_ready) begin
                    next         = RESP;
                    n_rsp_result = md_result;
                    n_rsp_err    = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next      = IDLE;
                    n_rsp_err = 1'b0;
                end
            end
            default: next = IDLE;
        endcase

        if (wd_expire) begin
            next         = RESP;
            n_rsp_err    = 1'b1;
            n_rsp_result = '0;
        end

        state_change = (next != state);

        n_req_ready = (next == IDLE);
        n_rsp_valid = (next == RESP);
        n_md_load   = (next == LOAD_A) || (next == LOAD_B);
        n_md_start  = (next == START);
        n_md_op     = is_wait_state(next) || (next == START) ? n_op : 1'b0;
        n_md_data   = '0;
        if (next == LOAD_A || next == REL_A) n_md_data = n_a;
        if (next == LOAD_B || next == REL_B) n_md_data = n_b;
    end

endmodule
